// File: rtl/if_id_skid_reg.sv
// Elastic fetch/decode pipeline register: {pc+4, instruction} pairs pass through a
// 2-entry skid buffer with valid/ready on both sides, flush, and saturating statistics.
module if_id_skid_reg #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
    parameter int                     STAT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [PC_WIDTH-1:0]    adder_in,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PC_WIDTH-1:0]    adder_out,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [STAT_WIDTH-1:0]  stall_count,
    output logic [STAT_WIDTH-1:0]  flush_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                   vld_p0;
    logic [PC_WIDTH-1:0]    adder_p0;
    logic [INSTR_WIDTH-1:0] instr_p0;
    logic [PC_WIDTH-1:0]    adder_p1;
    logic [INSTR_WIDTH-1:0] instr_p1;

    logic accept;
    logic drain;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    assign vld_p0   = (state_q != EMPTY);
    assign in_ready = (state_q != TWO);
    assign accept   = in_valid & in_ready;
    assign drain    = vld_p0 & out_ready;

    always_ff @(posedge clk) begin
        if (rstn) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid word always moves up before anything newer can enter.
                if (drain) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // Stage p0 = main (drives outputs), stage p1 = skid; data regs have no reset.
    always_ff @(posedge clk) begin
        if (load_main) begin
            adder_p0 <= main_from_skid ? adder_p1 : adder_in;
            instr_p0 <= main_from_skid ? instr_p1 : instruction_in;
        end
        if (load_skid) begin
            adder_p1 <= adder_in;
            instr_p1 <= instruction_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (vld_p0 && !out_ready && !flush) stall_count <= sat_inc(stall_count);
            if (flush)                          flush_count <= sat_inc(flush_count);
        end
    end

    assign out_valid       = vld_p0;
    assign adder_out       = vld_p0 ? adder_p0 : '0;
    assign instruction_out = vld_p0 ? instr_p0 : NOP_INSTR;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: reset, streaming, skid backpressure, flush and
// counter saturation (second instance with 4-bit counters).
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] adder_in;
    logic [31:0] instruction_in;
    logic        in_valid;
    logic        out_ready;
    logic        flush;

    logic        in_ready;
    logic [31:0] adder_out;
    logic [31:0] instruction_out;
    logic        out_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    logic        in_ready_s;
    logic [31:0] adder_out_s;
    logic [31:0] instruction_out_s;
    logic        out_valid_s;
    logic [3:0]  stall_count_s;
    logic [3:0]  flush_count_s;

    int vectors    = 0;
    int miscompares = 0;

    logic [65:0] got;
    logic [65:0] exp;

    always #5 clk = ~clk;

    if_id_skid_reg #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP), .STAT_WIDTH(16)
    ) dut (
        .clk(clk), .rstn(rstn), .adder_in(adder_in), .instruction_in(instruction_in),
        .in_valid(in_valid), .in_ready(in_ready), .adder_out(adder_out),
        .instruction_out(instruction_out), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
    );

    if_id_skid_reg #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP), .STAT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rstn(rstn), .adder_in(adder_in), .instruction_in(instruction_in),
        .in_valid(in_valid), .in_ready(in_ready_s), .adder_out(adder_out_s),
        .instruction_out(instruction_out_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .flush(flush), .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i);
        in_valid       = v;
        adder_in       = a;
        instruction_in = i;
    endtask

    task automatic test_reset();
        rstn = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'd0, 32'd0);
        step(); step();
        rstn = 1'b0;
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b0, 1'b1, 32'd0, NOP};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp);
        end
        vectors++;
        if ({stall_count, flush_count} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] a_tab [3] = '{32'd2, 32'd200, 32'd204};
        logic [31:0] i_tab [3] = '{32'd3, 32'd300, 32'd304};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, a_tab[k], i_tab[k]);
            step();
            got = {out_valid, in_ready, adder_out, instruction_out};
            exp = {1'b1, 1'b1, a_tab[k], i_tab[k]};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stream_word%0d: got %h expected %h", k, got, exp);
            end
        end
        drive(1'b0, 32'd0, 32'd0);
        step();
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b0, 1'b1, 32'd0, NOP};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL stream_drained: got %h expected %h", got, exp);
        end
        vectors++;
        if (stall_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stream_stall_count: got %0d expected 0", stall_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 32'd3);
        step();
        drive(1'b1, 32'd200, 32'd300);
        step();
        drive(1'b0, 32'd0, 32'd0);
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b1, 1'b0, 32'd2, 32'd3};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL skid_full: got %h expected %h", got, exp);
        end
        vectors++;
        if (stall_count !== 16'd1) begin
            miscompares++;
            $display("FAIL skid_stall1: got %0d expected 1", stall_count);
        end
        step(); step();
        got = {out_valid, in_ready, adder_out, instruction_out};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL skid_hold: got %h expected %h", got, exp);
        end
        vectors++;
        if (stall_count !== 16'd3) begin
            miscompares++;
            $display("FAIL skid_stall3: got %0d expected 3", stall_count);
        end
        out_ready = 1'b1;
        step();
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b1, 1'b1, 32'd200, 32'd300};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL skid_second: got %h expected %h", got, exp);
        end
        step();
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b0, 1'b1, 32'd0, NOP};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL skid_empty: got %h expected %h", got, exp);
        end
        vectors++;
        if (stall_count !== 16'd3) begin
            miscompares++;
            $display("FAIL skid_stall_final: got %0d expected 3", stall_count);
        end
    endtask

    task automatic test_flush_two();
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 32'd3);
        step();
        drive(1'b1, 32'd200, 32'd300);
        step();
        drive(1'b1, 32'd8, 32'd9);
        flush = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush2_in_ready: got %b expected 0", in_ready);
        end
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b0, 1'b1, 32'd0, NOP};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL flush2_empty: got %h expected %h", got, exp);
        end
        vectors++;
        if ({flush_count, stall_count} !== {16'd1, 16'd4}) begin
            miscompares++;
            $display("FAIL flush2_counters: got flush=%0d stall=%0d expected 1/4", flush_count, stall_count);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush2_dropped: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush_one();
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 32'd3);
        step();
        drive(1'b1, 32'd8, 32'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b0, 1'b1, 32'd0, NOP};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL flush1_empty: got %h expected %h", got, exp);
        end
        vectors++;
        if (flush_count !== 16'd2) begin
            miscompares++;
            $display("FAIL flush1_count: got %0d expected 2", flush_count);
        end
        drive(1'b1, 32'd12, 32'd13);
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'd0, 32'd0);
        got = {out_valid, in_ready, adder_out, instruction_out};
        exp = {1'b1, 1'b1, 32'd12, 32'd13};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL flush1_next_word: got %h expected %h", got, exp);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush1_drained: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        rstn = 1'b1; out_ready = 1'b0; drive(1'b0, 32'd0, 32'd0);
        step();
        rstn = 1'b0;
        vectors++;
        if ({stall_count_s, flush_count_s} !== 8'd0) begin
            miscompares++;
            $display("FAIL sat_reset: got stall=%0d flush=%0d expected 0/0", stall_count_s, flush_count_s);
        end
        drive(1'b1, 32'd5, 32'd6);
        step();
        drive(1'b0, 32'd0, 32'd0);
        repeat (20) step();
        vectors++;
        if ({stall_count_s, stall_count} !== {4'd15, 16'd20}) begin
            miscompares++;
            $display("FAIL sat_stall20: got small=%0d wide=%0d expected 15/20", stall_count_s, stall_count);
        end
        step();
        vectors++;
        if ({stall_count_s, stall_count} !== {4'd15, 16'd21}) begin
            miscompares++;
            $display("FAIL sat_hold: got small=%0d wide=%0d expected 15/21", stall_count_s, stall_count);
        end
        vectors++;
        if ({out_valid_s, adder_out_s, instruction_out_s} !== {1'b1, 32'd5, 32'd6}) begin
            miscompares++;
            $display("FAIL sat_data_held: got %b %h %h expected 1 5 6", out_valid_s, adder_out_s, instruction_out_s);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_flush_one();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised, elastic successor to the fetch/decode pipeline register. It sits between instruction fetch and decode and captures `{pc+4, instruction}` pairs. Its valid/ready handshake on both sides replaces the single `hit` qualifier. A 2-entry skid structure sustains one transfer per cycle with a fully registered `in_ready`. It adds flush (bubble insertion) and saturating stall/flush statistics counters.

## Interface
- `PC_WIDTH`, 32, width of the adder (pc+4) field
- `INSTR_WIDTH`, 32, width of the instruction field
- `NOP_INSTR`, 32'h0000_0000 (INSTR_WIDTH bits), instruction driven when output is not valid
- `STAT_WIDTH`, 16, width of each statistics counter

- `clk`  in  1  sole clock; all state updates on rising edge
- `rstn`  in  1  synchronous, active-high reset (asserted = 1)
- `adder_in`  in  PC_WIDTH  pc+4 from fetch
- `instruction_in`  in  INSTR_WIDTH  fetched instruction
- `in_valid`  in  1  fetch has a word (cache hit)
- `in_ready`  out  1  block can accept this cycle
- `adder_out`  out  PC_WIDTH  pc+4 to decode
- `instruction_out`  out  INSTR_WIDTH  instruction to decode
- `out_valid`  out  1  output pair is valid
- `out_ready`  in  1  decode consumes this cycle (not stalled)
- `flush`  in  1  discard all held and incoming words
- `stall_count`  out  STAT_WIDTH  cycles with `out_valid & !out_ready`
- `flush_count`  out  STAT_WIDTH  cycles with `flush` asserted

## Operation
- Storage: main register (feeds outputs) and skid register, each with a valid bit.
- Events: accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- States: EMPTY (none valid), ONE (main valid), TWO (main + skid valid).
- `in_ready` = (state != TWO), decoded from registered state only.
- `out_valid` = main valid. When `out_valid` = 0, `instruction_out` = `NOP_INSTR` and `adder_out` = 0.
- Transitions, when `flush` = 0:
  - EMPTY: accept -> ONE, main <= input. Otherwise stay.
  - ONE: accept & drain -> ONE, main <= input. Accept only -> TWO, skid <= input. Drain only -> EMPTY. Neither -> hold.
  - TWO: drain -> ONE, main <= skid. Otherwise hold. No accept is possible.
- Order is preserved: skid contents always leave before any newer word.
- `flush` = 1, highest priority below reset:
  - next state EMPTY; both valid bits cleared.
  - An input offered that cycle is dropped; `in_ready` still reflects current state.
  - A drain in the same cycle counts as completed for decode.
- `stall_count`: +1 each cycle `out_valid & !out_ready & !flush`; saturates at all-ones.
- `flush_count`: +1 each cycle `flush` = 1; saturates at all-ones.
- Data registers load only on their enables; held data never changes while valid.

## Timing
- Reset values, one edge after `rstn` = 1:
  - state EMPTY; `out_valid` = 0, `in_ready` = 1.
  - `instruction_out` = `NOP_INSTR`, `adder_out` = 0.
  - both counters = 0.
- `rstn` overrides `flush` and all handshakes. Reset mid-operation drops all words and does not count as a flush.
- Latency: a word accepted at edge N appears on outputs after edge N (visible cycle N+1) when the block was EMPTY, or was ONE with a simultaneous drain.
- Throughput: 1 word/cycle with `out_ready` held high.
- `in_ready` falls the cycle after the second word is buffered without a drain. It rises the cycle after the next drain.
- No combinational path from `out_ready` or `flush` to `in_ready`, and none from inputs to `out_valid` or data outputs.

## Test plan
- **Reset:** `rstn` = 1 for 2 cycles, then 0 -> `out_valid` = 0, `in_ready` = 1, `instruction_out` = `NOP_INSTR`, `adder_out` = 0, counters 0.
- **Streaming:** `out_ready` = 1; present (2,3), (200,300), (204,304) back-to-back -> same pairs on outputs one cycle later, in order, `in_ready` held 1.
- **Backpressure/skid:** `out_ready` = 0; accept (2,3) then (200,300) -> `in_ready` = 0 next cycle, output holds (2,3), `stall_count` increments per cycle. Raise `out_ready` -> (2,3) then (200,300) emerge, `in_ready` returns to 1.
- **Flush in TWO with input offered:** -> next cycle EMPTY, `out_valid` = 0, outputs `NOP_INSTR`/0, `flush_count` = 1. Input is not accepted (`in_ready` = 0 that cycle).
- **Flush in ONE with in_valid = 1:** input (8,9) dropped -> next cycle `out_valid` = 0. A following accept of (12,13) appears normally.
- **Saturation:** `STAT_WIDTH` = 4, stall 20 cycles -> `stall_count` = 15 and holds.
